// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the execute-stage hazard scoreboard.
// Forwarding is enabled by defining HAZARD_SCOREBOARD_FWD_EN.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_decode.sv
// Register-usage decode of one RV32 instruction word; shared with execute.
module sb_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o,
  output logic        writes_rd_o,
  output logic        is_load_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  logic [6:0] op;
  logic       unused_bits;

  assign op          = ir_i[6:0];
  assign rd_o        = ir_i[11:7];
  assign rs1_o       = ir_i[19:15];
  assign rs2_o       = ir_i[24:20];
  assign unused_bits = ^{ir_i[31:25], ir_i[14:12]};

  assign uses_rs1_o  = !(op == OP_JAL || op == OP_AUIPC || op == OP_LUI);
  assign uses_rs2_o  = (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  assign writes_rd_o = !(op == OP_BRANCH || op == OP_STORE) && (rd_o != 5'd0);
  assign is_load_o   = (op == OP_LOAD);

endmodule

// File: rtl/hazard_scoreboard.sv
// Central EX/MEM/WB destination scoreboard: issue gating and forwarding selects.
// Define HAZARD_SCOREBOARD_FWD_EN for forwarding; otherwise any in-flight match stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_ir,
  input  logic             id_v,
  output logic             id_r,
  input  logic             adv,
  input  logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  sb_decode u_dec (
    .ir_i        (id_ir),
    .uses_rs1_o  (uses_rs1),
    .uses_rs2_o  (uses_rs2),
    .writes_rd_o (writes_rd),
    .is_load_o   (is_load),
    .rs1_o       (rs1),
    .rs2_o       (rs2),
    .rd_o        (rd)
  );

  slot_t            ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][4:0]  src;
  logic [1:0]       src_used, src_hz;
  logic [1:0][1:0]  sel;
  logic             accept;

  assign src      = {rs2, rs1};
  assign src_used = {uses_rs2, uses_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    logic live, m_ex, m_mem, m_wb;
    // x0 is hard-wired zero: never a dependency.
    assign live  = src_used[g] && (src[g] != 5'd0);
    assign m_ex  = live && slot_hit(ex_q,  src[g]);
    assign m_mem = live && slot_hit(mem_q, src[g]);
    assign m_wb  = live && slot_hit(wb_q,  src[g]);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    assign src_hz[g] = m_ex && ex_q.is_load;
    assign sel[g]    = m_ex  ? FWD_EX  :
                       m_mem ? FWD_MEM :
                       m_wb  ? FWD_WB  : FWD_REG;
`else
    // Regfile is written as the producer leaves WB, so wait out all three slots.
    assign src_hz[g] = m_ex | m_mem | m_wb;
    assign sel[g]    = FWD_REG;
`endif
  end

  assign hazard    = |src_hz;
  assign fwd_sel_a = sel[0];
  assign fwd_sel_b = sel[1];
  assign id_r      = adv & ~hazard & ~flush;
  assign accept    = id_v & id_r;
  assign stall_cnt = cnt_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (adv) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      // Branches/stores and rd==x0 enter as bubbles.
      if (accept && writes_rd) begin
        ex_d.valid   = 1'b1;
        ex_d.rd      = rd;
        ex_d.is_load = is_load;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (id_v && !id_r && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an in-flight-list reference model.
module tb_hazard_scoreboard;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_v = 1'b0, adv = 1'b1, flush = 1'b0;
  logic [31:0]      id_ir = '0;
  logic             id_r, hazard;
  logic [1:0]       fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // In-flight destinations, youngest first; rd 0 means nothing to track.
  int m_rd[3];
  bit m_ld[3];
  int m_cnt;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_ir     (id_ir),
    .id_v      (id_v),
    .id_r      (id_r),
    .adv       (adv),
    .flush     (flush),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b),
    .hazard    (hazard),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] s_sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic void dec(input logic [31:0] ir, output bit u1, output bit u2,
                              output bit wr, output bit ld);
    logic [6:0] op;
    op = ir[6:0];
    u1 = !(op == 7'b1101111 || op == 7'b0010111 || op == 7'b0110111);
    u2 = (op == 7'b1100011) || (op == 7'b0100011) || (op == 7'b0110011);
    wr = !(op == 7'b1100011 || op == 7'b0100011) && (ir[11:7] != 5'd0);
    ld = (op == 7'b0000011);
  endfunction

  function automatic void model_out(input logic [31:0] ir, input logic a, input logic f,
                                    output logic [1:0] sa, output logic [1:0] sb,
                                    output logic hz, output logic rdy);
    bit u[2];
    bit wr, ld, h;
    int s[2];
    int k;
    logic [1:0] sel[2];
    h = 1'b0;
    dec(ir, u[0], u[1], wr, ld);
    s[0] = int'(ir[19:15]);
    s[1] = int'(ir[24:20]);
    for (int j = 0; j < 2; j++) begin
      sel[j] = 2'b00;
      k = -1;
      if (u[j] && s[j] != 0)
        for (int i = 2; i >= 0; i--) if (m_rd[i] == s[j]) k = i;
      if (k >= 0) begin
        if (FWD) begin
          sel[j] = 2'(k + 1);
          if (k == 0 && m_ld[0]) h = 1'b1;
        end else h = 1'b1;
      end
    end
    sa  = sel[0];
    sb  = sel[1];
    hz  = h;
    rdy = a && !h && !f;
  endfunction

  always @(posedge clk) begin : model_step
    logic [1:0] sa, sb;
    logic hz, rdy;
    bit u1, u2, wr, ld;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin m_rd[i] = 0; m_ld[i] = 1'b0; end
      m_cnt = 0;
    end else begin
      model_out(id_ir, adv, flush, sa, sb, hz, rdy);
      if (id_v && !rdy && m_cnt < CNT_MAX) m_cnt++;
      if (adv) begin
        dec(id_ir, u1, u2, wr, ld);
        m_rd[2] = m_rd[1]; m_ld[2] = m_ld[1];
        m_rd[1] = m_rd[0]; m_ld[1] = m_ld[0];
        m_rd[0] = (id_v && rdy && wr) ? int'(id_ir[11:7]) : 0;
        m_ld[0] = id_v && rdy && wr && ld;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] sa, sb;
    logic hz, rdy;
    if (chk_en) begin
      model_out(id_ir, adv, flush, sa, sb, hz, rdy);
      checks++;
      if ({id_r, hazard, fwd_sel_a, fwd_sel_b, stall_cnt} !==
          {rdy, hz, sa, sb, CNT_W'(m_cnt)}) begin
        errors++;
        $display("FAIL model_cycle t=%0t got r=%b hz=%b a=%b b=%b cnt=%0d need r=%b hz=%b a=%b b=%b cnt=%0d",
                 $time, id_r, hazard, fwd_sel_a, fwd_sel_b, stall_cnt, rdy, hz, sa, sb, m_cnt);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h need=%0h", nm, got, exp);
    end
  endtask

  task automatic present(input logic [31:0] ir, input logic v, input logic a, input logic f);
    @(posedge clk);
    #2;
    id_ir = ir; id_v = v; adv = a; flush = f;
    #1;
  endtask

  // Holds ir valid until accepted; returns in the accepting cycle.
  task automatic issue(input string nm, input logic [31:0] ir, input int exp_stalls);
    int n;
    n = 0;
    present(ir, 1'b1, 1'b1, 1'b0);
    while (id_r !== 1'b1 && n < 8) begin
      n++;
      present(ir, 1'b1, 1'b1, 1'b0);
    end
    lit({nm, "_stalls"}, n, exp_stalls);
  endtask

  task automatic drain();
    repeat (3) present(32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    lit("reset_id_r", id_r, 1);
    lit("reset_hazard", hazard, 0);
    lit("reset_sel_a", fwd_sel_a, 0);
    lit("reset_cnt", stall_cnt, 0);

    // Back-to-back ALU dependency.
    issue("addi_x5", i_addi(5, 0, 1), 0);
    issue("add_x6", r_add(6, 5, 5), FWD ? 0 : 3);
    lit("alu_sel_a", fwd_sel_a, FWD ? 1 : 0);
    lit("alu_sel_b", fwd_sel_b, FWD ? 1 : 0);

    // Load-use.
    issue("lw_x7", i_lw(7, 1), 0);
    issue("add_x8", r_add(8, 7, 2), FWD ? 1 : 3);
    lit("lu_sel_a", fwd_sel_a, FWD ? 2 : 0);
    lit("lu_sel_b", fwd_sel_b, 0);
    lit("lu_cnt", stall_cnt, FWD ? 1 : 6);

    // Store is tracked as a bubble; x0 never matches.
    drain();
    issue("sw", s_sw(3, 4), 0);
    issue("add_x9", r_add(9, 0, 3), 0);
    lit("x0_sel_a", fwd_sel_a, 0);
    lit("x0_sel_b", fwd_sel_b, 0);

    // Flush dominates a load-use hazard.
    drain();
    issue("lw_x7b", i_lw(7, 1), 0);
    present(r_add(8, 7, 7), 1'b1, 1'b1, 1'b1);
    lit("flush_id_r", id_r, 0);
    lit("flush_hazard", hazard, 1);
    issue("add_after_flush", r_add(8, 7, 7), FWD ? 0 : 2);
    lit("flush_next_sel_a", fwd_sel_a, FWD ? 2 : 0);
    lit("flush_cnt", stall_cnt, FWD ? 2 : 9);

    // Hold with the same rd in EX and MEM.
    drain();
    issue("x5_first", i_addi(5, 0, 1), 0);
    issue("x5_second", i_addi(5, 5, 1), FWD ? 0 : 3);
    for (int i = 0; i < 3; i++) begin
      present(r_add(6, 5, 5), 1'b1, 1'b0, 1'b0);
      lit("hold_id_r", id_r, 0);
      lit("hold_sel_a", fwd_sel_a, FWD ? 1 : 0);
      lit("hold_sel_b", fwd_sel_b, FWD ? 1 : 0);
    end
    issue("hold_release", r_add(6, 5, 5), FWD ? 0 : 3);
    lit("hold_cnt", stall_cnt, FWD ? 5 : 18);

    // Reset mid-flight discards the load.
    issue("lw_x7c", i_lw(7, 1), 0);
    @(posedge clk); #2 rst_n = 1'b0; id_v = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    lit("midrst_cnt", stall_cnt, 0);
    issue("after_rst", r_add(8, 7, 2), 0);
    lit("after_rst_sel_a", fwd_sel_a, 0);

    // Saturation of the stall counter.
    present(r_add(6, 5, 5), 1'b1, 1'b0, 1'b0);
    repeat (CNT_MAX + 5) @(posedge clk);
    #3;
    lit("sat_cnt", stall_cnt, 32'hFFFF);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1; id_v = 1'b0; adv = 1'b1;
    #1;
    lit("sat_rst_cnt", stall_cnt, 0);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue controller for the execute stage of the 5-stage RISC-V pipeline. It tracks destination registers of instructions in flight in EX, MEM and WB, and decides whether the decoded instruction may enter execute. It also drives the rs1/rs2 forwarding-mux selects for the execute datapath. It sits between decode and execute, and replaces the execute stage's private waitlist with one central scoreboard.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_ir  in  32  instruction word presented by decode
- id_v  in  1  id_ir valid
- id_r  out  1  scoreboard/execute can accept id_ir this cycle
- adv  in  1  whole pipeline advances this cycle (downstream not back-pressuring)
- flush  in  1  taken branch/jump resolved; instruction in decode is squashed
- fwd_sel_a  out  2  rs1 source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- fwd_sel_b  out  2  rs2 source, same encoding
- hazard  out  1  raw hazard on the current id_ir (independent of adv)
- stall_cnt  out  CNT_W  cycles with id_v=1 and id_r=0, saturating

## Operation
- Three slots (EX, MEM, WB), each holds {valid, rd[4:0], is_load}.
- Decode of id_ir:
  - uses_rs1 unless opcode is 1101111 (JAL), 0010111 (AUIPC) or 0110111 (LUI).
  - uses_rs2 for 1100011 (branch), 0100011 (store) and 0110011 (R-type).
  - writes_rd unless the opcode is branch or store, and never when rd==0.
  - is_load when opcode is 0000011.
- A register x0 source never matches, never hazards and always selects 00.
- Match for a source: the source is used, a slot is valid, and slot.rd equals the source. Priority is EX > MEM > WB, so the youngest producer wins.
- With forwarding compiled in:
  - hazard=1 only when the EX-slot match has is_load=1 (load-use).
  - Otherwise fwd_sel is the encoding of the highest-priority matching slot, or 00 when there is no match.
- id_r = adv & ~hazard & ~flush.
- Accept = id_v & id_r.
- On a cycle with adv=1, slots shift: WB<=MEM, MEM<=EX.
  - EX<=decoded id_ir when accepted.
  - EX<=bubble (valid=0) otherwise, which covers stall, flush and id_v=0.
- On a cycle with adv=0, all slots hold.
- Non-writing instructions (branch/store) enter EX with valid=0 in the rd sense, i.e. they are tracked as bubbles.
- stall_cnt increments when id_v & ~id_r and stops at all-ones. It is reset only by rst_n.

## Timing
- fwd_sel_a, fwd_sel_b, hazard and id_r are combinational from the slot registers and id_ir, valid in the same cycle.
- Slot update and stall_cnt update happen on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - All slots become invalid and stall_cnt becomes 0.
  - Outputs then read: fwd_sel=00, hazard=0, id_r=adv.
- Reset mid-operation discards in-flight tracking immediately.
- Load-use costs exactly one bubble: the load moves to MEM, and next cycle fwd_sel=10 with hazard=0.
- flush and hazard in the same cycle: flush dominates, EX takes a bubble, and stall_cnt counts it if id_v=1.
- flush=1 with adv=0: no shift occurs, and the flush must be held by its source until adv=1.
- Same rd in EX and MEM: EX is selected (01).
- rs1==rs2 with a match: both selects are identical.

## Configuration
- HAZARD_SCOREBOARD_FWD_EN defined: forwarding behaviour as above.
- Undefined: fwd_sel_a and fwd_sel_b are tied to 00.
  - hazard=1 on any match in EX, MEM or WB.
  - The regfile writes at the WB exit edge, so a WB match also stalls.
  - Consequently a dependent instruction waits until its producer leaves WB.

## Structure
- Shared package holds:
  - opcode constants: OP_JAL, OP_AUIPC, OP_LUI, OP_BRANCH, OP_STORE, OP_OP, OP_LOAD
  - FWD_REG, FWD_EX, FWD_MEM, FWD_WB select constants
  - the slot struct {valid, rd, is_load}
- One sub-module, sb_decode: combinational, id_ir -> {uses_rs1, uses_rs2, writes_rd, is_load, rs1, rs2, rd}, so that execute can reuse it.

## Test plan
- **Back-to-back ALU dependency (FWD_EN):** addi x5,x0,1 then add x6,x5,x5 with adv=1 → second cycle fwd_sel_a=fwd_sel_b=01, hazard=0, id_r=1.
- **Load-use (FWD_EN):** lw x7,0(x1) then add x8,x7,x2 → hazard=1 and id_r=0 for one cycle, stall_cnt=1; next cycle fwd_sel_a=10 and the add is accepted.
- **x0 and non-writers:** sw x3,0(x4) then add x9,x0,x3 → fwd_sel_a=00 with no match from the store; rd=0 producers are never forwarded.
- **Flush versus stall:** lw x7 in EX, add x8,x7,x7 pending, flush=1 → id_r=0, EX becomes a bubble, stall_cnt increments, and the next cycle shows no hazard.
- **Hold/priority:** adv=0 for 3 cycles with x5 in both EX and MEM → slots unchanged, id_r=0, fwd_sel=01 throughout.
- **FWD_EN undefined, and reset:**
  - addi x5 then add x6,x5,x0 → hazard held 3 cycles, then accepted with fwd_sel=00.
  - stall_cnt forced near all-ones saturates at 0xFFFF.
  - rst_n=0 then clears it to 0.
